// File: rtl/midi_tx.sv
`default_nettype none
// ============================================================================
// Module      : midi_tx
// Description : MIDI 1.0 serial transmitter. Accepts note-on/note-off events
//               over a valid/ready handshake, builds 3-byte channel voice
//               messages (optionally using running status) and shifts them out
//               as UART 8N1 frames.
// Ports       : clk          system clock
//               rst_n        synchronous reset, active low
//               ev_valid     event request
//               ev_ready     high when an event can be accepted (state IDLE)
//               ev_note_on   1 = note-on (0x9n), 0 = note-off (0x8n)
//               ev_channel   MIDI channel 0..15
//               ev_note      note number (data byte 1)
//               ev_velocity  velocity (data byte 2)
//               midi_out     serial line, idle high
//               busy         high while a message is being shifted
// Revision    : 1.0  initial release
// ============================================================================
module midi_tx #(
    parameter int CLKSPEED       = 48_000_000,
    parameter int BAUD           = 31_250,
    parameter bit RUNNING_STATUS = 1'b1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ev_valid,
    output logic       ev_ready,
    input  logic       ev_note_on,
    input  logic [3:0] ev_channel,
    input  logic [6:0] ev_note,
    input  logic [6:0] ev_velocity,
    output logic       midi_out,
    output logic       busy
);

    localparam int c_BIT_CLKS = CLKSPEED / BAUD;
    localparam int c_TIMER_W  = (c_BIT_CLKS > 2) ? $clog2(c_BIT_CLKS) : 1;
    localparam logic [c_TIMER_W-1:0] c_TIMER_RELOAD = c_TIMER_W'(c_BIT_CLKS - 1);

    generate
        if (c_BIT_CLKS < 2) begin : g_bit_clks_check
            $error("midi_tx: CLKSPEED/BAUD must be at least 2");
        end
    endgenerate

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } state_t;

    state_t                 r_state,       w_state;
    logic [c_TIMER_W-1:0]   r_timer,       w_timer;
    logic [2:0]             r_bit_idx,     w_bit_idx;
    logic [1:0]             r_byte_idx,    w_byte_idx;   // byte being sent: 0 status, 1 note, 2 velocity
    logic [1:0][7:0]        r_data,        w_data;       // [0] note byte, [1] velocity byte
    logic [7:0]             r_shift,       w_shift;
    logic [7:0]             r_cache,       w_cache;
    logic                   r_cache_valid, w_cache_valid;
    logic                   r_out,         w_out;
    logic                   r_busy,        w_busy;

    logic [7:0]             w_status;
    logic                   w_rs_hit;
    logic                   w_timer_done;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state       <= ST_IDLE;
            r_timer       <= '0;
            r_bit_idx     <= '0;
            r_byte_idx    <= '0;
            r_data        <= '0;
            r_shift       <= '0;
            r_cache       <= '0;
            r_cache_valid <= 1'b0;
            r_out         <= 1'b1;
            r_busy        <= 1'b0;
        end else begin
            r_state       <= w_state;
            r_timer       <= w_timer;
            r_bit_idx     <= w_bit_idx;
            r_byte_idx    <= w_byte_idx;
            r_data        <= w_data;
            r_shift       <= w_shift;
            r_cache       <= w_cache;
            r_cache_valid <= w_cache_valid;
            r_out         <= w_out;
            r_busy        <= w_busy;
        end
    end

    always_comb begin
        w_state       = r_state;
        w_timer       = r_timer;
        w_bit_idx     = r_bit_idx;
        w_byte_idx    = r_byte_idx;
        w_data        = r_data;
        w_shift       = r_shift;
        w_cache       = r_cache;
        w_cache_valid = r_cache_valid;
        w_out         = r_out;
        w_busy        = r_busy;

        w_status     = {1'b1, (ev_note_on ? 3'b001 : 3'b000), ev_channel};
        w_rs_hit     = RUNNING_STATUS && r_cache_valid && (w_status == r_cache);
        w_timer_done = (r_timer == '0);

        // The timer counts down once per clock and stops at zero; every bit
        // transition below reloads it so each level lasts exactly c_BIT_CLKS.
        if (r_state != ST_IDLE && !w_timer_done) begin
            w_timer = r_timer - 1'b1;
        end

        case (r_state)
            ST_IDLE: begin
                if (ev_valid) begin
                    w_data    = {{1'b0, ev_velocity}, {1'b0, ev_note}};
                    w_bit_idx = '0;
                    w_timer   = c_TIMER_RELOAD;
                    w_state   = ST_START;
                    w_out     = 1'b0;
                    w_busy    = 1'b1;
                    if (w_rs_hit) begin
                        // Status already on the wire: start with the note byte.
                        w_byte_idx = 2'd1;
                        w_shift    = {1'b0, ev_note};
                    end else begin
                        w_byte_idx    = 2'd0;
                        w_shift       = w_status;
                        w_cache       = w_status;
                        w_cache_valid = 1'b1;
                    end
                end
            end

            ST_START: begin
                if (w_timer_done) begin
                    w_state   = ST_DATA;
                    w_timer   = c_TIMER_RELOAD;
                    w_bit_idx = '0;
                    w_out     = r_shift[0];
                end
            end

            ST_DATA: begin
                if (w_timer_done) begin
                    w_timer = c_TIMER_RELOAD;
                    if (r_bit_idx == 3'd7) begin
                        w_state = ST_STOP;
                        w_out   = 1'b1;
                    end else begin
                        // LSB-first: the register shifts right, bit 1 is next.
                        w_bit_idx = r_bit_idx + 3'd1;
                        w_shift   = {1'b0, r_shift[7:1]};
                        w_out     = r_shift[1];
                    end
                end
            end

            ST_STOP: begin
                if (w_timer_done) begin
                    if (r_byte_idx != 2'd2) begin
                        // Next byte starts immediately: no idle gap inside a message.
                        w_shift    = r_data[r_byte_idx[0]];
                        w_byte_idx = r_byte_idx + 2'd1;
                        w_state    = ST_START;
                        w_timer    = c_TIMER_RELOAD;
                        w_out      = 1'b0;
                    end else begin
                        w_state = ST_IDLE;
                        w_busy  = 1'b0;
                    end
                end
            end

            default: begin
                w_state = ST_IDLE;
                w_out   = 1'b1;
                w_busy  = 1'b0;
            end
        endcase
    end

    assign ev_ready = (r_state == ST_IDLE);
    assign midi_out = r_out;
    assign busy     = r_busy;

endmodule
`default_nettype wire
